viterbi_decoder: RTL and testbench

- Hard-decision Viterbi decoder for the rate-1/2, K=3 convolutional code produced by the transmit-side encoder: generators g0=111 and g1=101, with 4 trellis states.
- Sits directly downstream of the encoder/channel model. It consumes one 2-bit code symbol per accepted cycle and emits one decoded data bit per accepted symbol after a fixed survivor depth.
- Uses register-exchange survivor storage, so latency is deterministic.

---
 rtl/viterbi_decoder.sv | 177 +++++++++++++++++
 tb/tb_viterbi_decoder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_decoder.sv
// Hard-decision Viterbi decoder for the rate-1/2, K=3 code (g0=111, g1=101).
// Four trellis states, register-exchange survivors, fixed decode delay of
// TB_DEPTH accepted symbols (output registered one clock after acceptance).
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   code_in carries a symbol this cycle
//   code_in    {c1, c0}: c0 = d^s0^s1, c1 = d^s1
//   out_valid  one-cycle pulse, data_out is a decoded bit
//   data_out   decoded data bit (holds between pulses)
//   err_count  (only with VITERBI_ERRCNT_EN) saturating count of channel bit
//              errors, found by re-encoding the decoded stream
//
// Optional feature macro: VITERBI_ERRCNT_EN
module viterbi_decoder #(
  parameter int unsigned TB_DEPTH = 15,
  parameter int unsigned PM_W     = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [1:0]  code_in,
  output logic        out_valid,
  output logic        data_out
`ifdef VITERBI_ERRCNT_EN
  ,
  output logic [15:0] err_count
`endif
);

  localparam int unsigned NS    = 4;
  localparam int unsigned SUM_W = PM_W + 1;
  localparam int unsigned CNT_W = $clog2(TB_DEPTH);
  localparam logic [PM_W-1:0]  PM_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TB_DEPTH - 1);

  // Hamming distance between a received symbol and the symbol expected when
  // leaving state st={s1,s0} with input d.
  function automatic logic [1:0] branch_metric(input logic [1:0] sym,
                                               input logic [1:0] st,
                                               input logic       d);
    logic [1:0] exp_sym;
    logic [1:0] diff;
    exp_sym = {d ^ st[1], d ^ st[0] ^ st[1]};
    diff    = sym ^ exp_sym;
    return 2'(diff[0]) + 2'(diff[1]);
  endfunction

  function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] a,
                                              input logic [1:0]      b);
    logic [SUM_W-1:0] sum;
    sum = {1'b0, a} + SUM_W'(b);
    return sum[PM_W] ? PM_MAX : sum[PM_W-1:0];
  endfunction

  logic [PM_W-1:0]     pm_q     [NS];
  logic [TB_DEPTH-1:0] surv_q   [NS];
  logic [CNT_W-1:0]    cnt_q;

  logic [PM_W-1:0]     pm_new   [NS];
  logic [PM_W-1:0]     pm_norm  [NS];
  logic [TB_DEPTH-1:0] surv_new [NS];
  logic [PM_W-1:0]     pm_min;
  logic [1:0]          best;
  logic [1:0]          ns_st;
  logic [1:0]          pred0;
  logic [1:0]          pred1;
  logic [PM_W-1:0]     cand0;
  logic [PM_W-1:0]     cand1;

  // Add-compare-select, best-state search and normalisation.
  always_comb begin
    ns_st  = '0;
    pred0  = '0;
    pred1  = '0;
    cand0  = '0;
    cand1  = '0;
    pm_min = '0;
    best   = '0;
    for (int unsigned i = 0; i < NS; i++) begin
      pm_new[i]   = '0;
      pm_norm[i]  = '0;
      surv_new[i] = '0;
    end

    for (int unsigned i = 0; i < NS; i++) begin
      ns_st = 2'(i);
      // Both predecessors of {s1,s0} share s0' = s1 of the next state.
      pred0 = {1'b0, ns_st[1]};
      pred1 = {1'b1, ns_st[1]};
      cand0 = sat_add(pm_q[pred0], branch_metric(code_in, pred0, ns_st[0]));
      cand1 = sat_add(pm_q[pred1], branch_metric(code_in, pred1, ns_st[0]));
      // Ties favour the predecessor with s1=0.
      if (cand0 <= cand1) begin
        pm_new[ns_st]   = cand0;
        surv_new[ns_st] = {surv_q[pred0][TB_DEPTH-2:0], ns_st[0]};
      end else begin
        pm_new[ns_st]   = cand1;
        surv_new[ns_st] = {surv_q[pred1][TB_DEPTH-2:0], ns_st[0]};
      end
    end

    // Strict compare keeps the lowest index on ties.
    pm_min = pm_new[0];
    best   = 2'd0;
    for (int unsigned i = 1; i < NS; i++) begin
      ns_st = 2'(i);
      if (pm_new[ns_st] < pm_min) begin
        pm_min = pm_new[ns_st];
        best   = ns_st;
      end
    end

    for (int unsigned i = 0; i < NS; i++) begin
      ns_st          = 2'(i);
      pm_norm[ns_st] = pm_new[ns_st] - pm_min;
    end
  end

  // Metric/survivor state, warm-up counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NS; i++) begin
        pm_q[2'(i)]   <= (i == 0) ? '0 : PM_MAX;
        surv_q[2'(i)] <= '0;
      end
      cnt_q     <= '0;
      out_valid <= 1'b0;
      data_out  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        pm_q   <= pm_norm;
        surv_q <= surv_new;
        if (cnt_q != CNT_LAST) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
        out_valid <= (cnt_q == CNT_LAST);
        data_out  <= surv_new[best][TB_DEPTH-1];
      end
    end
  end

`ifdef VITERBI_ERRCNT_EN
  // Received symbols delayed TB_DEPTH accepted symbols, newest in the LSBs.
  logic [2*TB_DEPTH-1:0] dly_q;
  logic [1:0]            enc_q;
  logic [1:0]            err_inc;

  always_comb begin
    err_inc = branch_metric(dly_q[2*TB_DEPTH-1 -: 2], enc_q, data_out);
  end

  // Re-encode each emitted bit and compare with its original symbol.
  always_ff @(posedge clk) begin
    if (reset) begin
      dly_q     <= '0;
      enc_q     <= '0;
      err_count <= '0;
    end else begin
      if (in_valid) begin
        dly_q <= {dly_q[2*TB_DEPTH-3:0], code_in};
      end
      if (out_valid) begin
        enc_q <= {enc_q[0], data_out};
        if (err_count > (16'hFFFF - 16'(err_inc))) begin
          err_count <= 16'hFFFF;
        end else begin
          err_count <= err_count + 16'(err_inc);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_viterbi_decoder.sv
// Self-checking bench for viterbi_decoder. A transmit-side K=3 encoder drives
// the decoder; the reference model says each accepted symbol n >= TB_DEPTH-1
// must yield the data bit sent at symbol n-(TB_DEPTH-1), one clock later.
module tb_viterbi_decoder;

  localparam int unsigned TB_DEPTH = 15;
  localparam int unsigned LAT      = TB_DEPTH - 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [1:0] code_in;
  logic       out_valid;
  logic       data_out;
`ifdef VITERBI_ERRCNT_EN
  logic [15:0] err_count;
`endif

  viterbi_decoder #(.TB_DEPTH(TB_DEPTH), .PM_W(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .code_in   (code_in),
    .out_valid (out_valid),
    .data_out  (data_out)
`ifdef VITERBI_ERRCNT_EN
    ,
    .err_count (err_count)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic        chk_en   = 1'b0;

  // Reference model state.
  logic        exp_ov  = 1'b0;
  logic        exp_do  = 1'b0;
  int unsigned exp_err = 0;
  int unsigned pend    = 0;
  int unsigned n_acc   = 0;
  logic        data_q[$];
  int unsigned flip_q[$];
  logic [1:0]  tx_st   = 2'b00;

  // Observed output history.
  int unsigned ov_seen = 0;
  logic        got_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] enc(input logic d, input logic [1:0] st);
    return {d ^ st[1], d ^ st[0] ^ st[1]};
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", 32'(out_valid), 32'(exp_ov));
      check("data_out", 32'(data_out), 32'(exp_do));
`ifdef VITERBI_ERRCNT_EN
      check("err_count", 32'(err_count), exp_err);
`endif
      if (out_valid === 1'b1) begin
        ov_seen++;
        got_q.push_back(data_out);
      end
    end
  end

  // One clock: drive inputs, then advance the model past the edge.
  task automatic step(input logic rst, input logic v, input logic [1:0] sym,
                      input logic dbit, input int unsigned flips);
    @(negedge clk);
    reset    = rst;
    in_valid = v;
    code_in  = sym;
    @(posedge clk);
    if (rst) begin
      n_acc   = 0;
      data_q.delete();
      flip_q.delete();
      exp_ov  = 1'b0;
      exp_do  = 1'b0;
      exp_err = 0;
      pend    = 0;
    end else begin
      if (exp_ov) exp_err = (exp_err + pend > 65535) ? 65535 : exp_err + pend;
      exp_ov = 1'b0;
      if (v) begin
        data_q.push_back(dbit);
        flip_q.push_back(flips);
        if (n_acc >= LAT) begin
          exp_ov = 1'b1;
          exp_do = data_q[n_acc - LAT];
          pend   = flip_q[n_acc - LAT];
        end
        n_acc++;
      end
    end
  endtask

  task automatic send(input logic d, input logic [1:0] flip);
    logic [1:0] sym;
    sym   = enc(d, tx_st) ^ flip;
    tx_st = {tx_st[0], d};
    step(1'b0, 1'b1, sym, d, 32'(flip[0]) + 32'(flip[1]));
  endtask

  task automatic gap();
    step(1'b0, 1'b0, 2'($urandom_range(0, 3)), 1'b0, 0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b0, 0);
    tx_st  = 2'b00;
    chk_en = 1'b1;
  endtask

  // Stream 1,0,1,1 followed by 18 zeros; bit i of this word is the data bit.
  localparam logic [21:0] STREAM = 22'b0000000000000000001101;
  localparam logic [7:0]  FIRST8 = 8'b00001101;

  task automatic check_first8(input string name, input int unsigned gb);
    logic [7:0] lit;
    lit = FIRST8;
    check({name, "_count"}, got_q.size() - gb, 8);
    for (int i = 0; i < 8; i++) begin
      if (gb + i < got_q.size()) check({name, "_bit"}, 32'(got_q[gb + i]), 32'(lit[i]));
    end
  endtask

  initial begin : main
    logic [3:0]  pin_d;
    logic [1:0]  pin_sym [4];
    logic [1:0]  st;
    logic [21:0] stream;
    int unsigned base;
    int unsigned gb;
    int unsigned ones;
    logic        d;
    logic [1:0]  fl;

    reset    = 1'b1;
    in_valid = 1'b0;
    code_in  = 2'b00;

    // Pin the transmit encoder: data 1,0,1,1 must give 11,01,00,10.
    pin_d   = 4'b1101;
    pin_sym = '{2'b11, 2'b01, 2'b00, 2'b10};
    st      = 2'b00;
    for (int i = 0; i < 4; i++) begin
      check("enc_pin", 32'(enc(pin_d[i], st)), 32'(pin_sym[i]));
      st = {st[0], pin_d[i]};
    end

    // All-zero stream: first pulse only after symbol 14, six zero outputs.
    do_reset();
    base = ov_seen;
    gb   = got_q.size();
    repeat (15) send(1'b0, 2'b00);
    check("zero_no_early", ov_seen - base, 0);
    repeat (5) send(1'b0, 2'b00);
    gap();
    check("zero_count", ov_seen - base, 6);
    ones = 0;
    for (int i = gb; i < got_q.size(); i++) ones += 32'(got_q[i]);
    check("zero_ones", ones, 0);

    // Clean known stream.
    stream = STREAM;
    do_reset();
    gb = got_q.size();
    for (int i = 0; i < 22; i++) send(stream[i], 2'b00);
    gap();
    check_first8("clean", gb);

    // Same stream, bit0 flipped at symbol 5.
    do_reset();
    gb = got_q.size();
    for (int i = 0; i < 22; i++) send(stream[i], (i == 5) ? 2'b01 : 2'b00);
    gap();
    gap();
    check_first8("flip", gb);
`ifdef VITERBI_ERRCNT_EN
    #1;
    check("flip_errcnt", 32'(err_count), 1);
`endif

    // Same clean stream with three idle cycles every two symbols.
    do_reset();
    gb = got_q.size();
    for (int i = 0; i < 22; i++) begin
      send(stream[i], 2'b00);
      if (i % 2 == 1) repeat (3) gap();
    end
    gap();
    check_first8("gaps", gb);

    // Mid-stream reset discards history.
    do_reset();
    for (int i = 0; i < 10; i++) send(1'($urandom_range(0, 1)), 2'b00);
    do_reset();
    base = ov_seen;
    gb   = got_q.size();
    repeat (15) send(1'b0, 2'b00);
    check("rst_no_early", ov_seen - base, 0);
    repeat (5) send(1'b0, 2'b00);
    gap();
    check("rst_count", ov_seen - base, 6);
    ones = 0;
    for (int i = gb; i < got_q.size(); i++) ones += 32'(got_q[i]);
    check("rst_ones", ones, 0);

    // 1000 random bits with one channel bit error every 20 symbols.
    do_reset();
    base = ov_seen;
    for (int i = 0; i < 1000; i++) begin
      d  = 1'($urandom_range(0, 1));
      fl = (i % 20 == 7) ? (($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10) : 2'b00;
      send(d, fl);
    end
    repeat (LAT) send(1'b0, 2'b00);
    gap();
    gap();
    check("rand_count", ov_seen - base, 1000);
`ifdef VITERBI_ERRCNT_EN
    #1;
    check("rand_errcnt", 32'(err_count), 50);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
